// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, issues request-to-send,
// shifts one odd-parity frame on device-generated clock edges and checks the device ACK.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_DONE,
    output logic       TX_ERROR,
    output logic       BUSY,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_DRIVE_LOW,
    output logic       PS2_DATA_DRIVE_LOW
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [INH_W-1:0]       inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   clk_drv_q, clk_drv_d;
    logic                   data_drv_q, data_drv_d;

    logic clk_s, data_s, fall, timeout;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q & ~clk_s;
    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK_IN};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], PS2_DATA_IN};
        clk_prev_d  = clk_s;
        inh_cnt_d   = inh_cnt_q;
        to_cnt_d    = to_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        clk_drv_d   = clk_drv_q;
        data_drv_d  = data_drv_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_drv_d  = 1'b0;
                data_drv_d = 1'b0;
                if (TX_VALID && ready_q) begin
                    // Frame is shifted LSB first: data, odd parity, stop.
                    shift_d   = {1'b1, ~^TX_DATA, TX_DATA};
                    inh_cnt_d = '0;
                    clk_drv_d = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_drv_d = 1'b1;
                    state_d    = S_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            S_RTS: begin
                clk_drv_d = 1'b0;
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                // Timeout wins over any clock edge arriving in the same cycle.
                if (timeout) begin
                    clk_drv_d  = 1'b0;
                    data_drv_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (state_q == S_SHIFT) begin
                        if (fall) begin
                            // Edge 10 shifts out the stop bit, which releases the line.
                            data_drv_d = ~shift_q[0];
                            shift_d    = {1'b0, shift_q[9:1]};
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd9) begin
                                state_d = S_ACK;
                            end
                        end
                    end else if (state_q == S_ACK) begin
                        if (fall) begin
                            if (data_s) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_WAIT_IDLE;
                            end
                        end
                    end else begin
                        if (clk_s && data_s) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                clk_drv_d  = 1'b0;
                data_drv_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        // Ready stays low through the completion pulse and rises one cycle later.
        ready_d = (state_d == S_IDLE) && !done_d && !err_d;
        busy_d  = !ready_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b0;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            clk_drv_q   <= 1'b0;
            data_drv_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            clk_drv_q   <= clk_drv_d;
            data_drv_q  <= data_drv_d;
        end
    end

    assign TX_READY           = ready_q;
    assign TX_DONE            = done_q;
    assign TX_ERROR           = err_q;
    assign BUSY               = busy_q;
    assign PS2_CLK_DRIVE_LOW  = clk_drv_q;
    assign PS2_DATA_DRIVE_LOW = data_drv_q;
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;
    localparam int INH  = 60;
    localparam int TO   = 2000;
    localparam int SYNC = 2;
    localparam int H    = 20;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       glitch   = 1'b0;

    logic tx_ready, tx_done, tx_error, busy, clk_drv, data_drv;
    logic ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = glitch | (~clk_drv & dev_clk);
    assign ps2_data_line = ~data_drv & dev_data;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .TX_DATA(tx_data),
        .TX_VALID(tx_valid),
        .TX_READY(tx_ready),
        .TX_DONE(tx_done),
        .TX_ERROR(tx_error),
        .BUSY(busy),
        .PS2_CLK_IN(ps2_clk_line),
        .PS2_DATA_IN(ps2_data_line),
        .PS2_CLK_DRIVE_LOW(clk_drv),
        .PS2_DATA_DRIVE_LOW(data_drv)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Event monitor sampled on the inactive edge.
    int         done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
    int         both_cnt = 0, long_cnt = 0, ready_viol = 0;
    int         release_cyc = 0, fall_cnt = 0, last_fall_cyc = 0;
    logic       ready_at_pulse = 1'b1, ready_after_pulse = 1'b0;
    logic [1:0] drv_at_pulse = 2'b00;
    logic       pulse_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0, drv_prev = 1'b0;
    logic       in_xfer = 1'b0;

    always @(negedge clk) begin
        if (pulse_prev) ready_after_pulse = tx_ready;
        if (tx_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (tx_error === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
        if ((tx_done === 1'b1 && done_prev) || (tx_error === 1'b1 && err_prev)) long_cnt++;
        if (tx_done === 1'b1 || tx_error === 1'b1) begin
            ready_at_pulse = tx_ready;
            drv_at_pulse   = {clk_drv, data_drv};
            in_xfer        = 1'b0;
        end else if (in_xfer && tx_ready === 1'b1) begin
            ready_viol++;
        end
        if (drv_prev && clk_drv === 1'b0) release_cyc = cyc;
        pulse_prev = (tx_done === 1'b1) || (tx_error === 1'b1);
        done_prev  = (tx_done === 1'b1);
        err_prev   = (tx_error === 1'b1);
        drv_prev   = (clk_drv === 1'b1);
    end

    task automatic start_tx(input logic [7:0] b, input int glitch_at);
        int inh;
        int guard;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept got %0b exp 1", tx_ready);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        in_xfer  = 1'b1;
        checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b1 || clk_drv !== 1'b1) begin
            errors++;
            $display("FAIL after_accept ready/busy/clkdrv got %0b%0b%0b exp 011", tx_ready, busy, clk_drv);
        end
        inh   = 0;
        guard = 0;
        while (clk_drv === 1'b1 && data_drv === 1'b0 && guard < 10 * INH) begin
            inh++;
            guard++;
            if (inh == glitch_at) glitch = 1'b1;
            @(negedge clk);
            glitch = 1'b0;
        end
        checks++;
        if (inh != INH) begin
            errors++;
            $display("FAIL inhibit_len got %0d exp %0d", inh, INH);
        end
        checks++;
        if (clk_drv !== 1'b1 || data_drv !== 1'b1) begin
            errors++;
            $display("FAIL rts clkdrv/datadrv got %0b%0b exp 11", clk_drv, data_drv);
        end
        @(negedge clk);
        checks++;
        if (clk_drv !== 1'b0 || data_drv !== 1'b1) begin
            errors++;
            $display("FAIL clk_release clkdrv/datadrv got %0b%0b exp 01", clk_drv, data_drv);
        end
    endtask

    // Device model: clocks n_edges falling edges, samples the line while clock is high.
    task automatic dev_frame(input int n_edges, input bit ack, output logic [9:0] bits);
        bits = '0;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= n_edges; i++) begin
            dev_clk = 1'b0;
            fall_cnt++;
            last_fall_cyc = cyc;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H / 2) @(negedge clk);
            if (i <= 10) bits[i-1] = ps2_data_line;
            if (i == 10 && ack) dev_data = 1'b0;
            if (i == 11) dev_data = 1'b1;
            repeat (H / 2) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_pulse(input int d0, input int e0, input int bound);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
    endtask

    task automatic run_xfer(input logic [7:0] b, input logic par, input int glitch_at);
        int         d0, e0;
        logic [9:0] bits;
        logic [9:0] exp_frame;
        d0 = done_cnt;
        e0 = err_cnt;
        exp_frame = {1'b1, par, b};
        start_tx(b, glitch_at);
        dev_frame(11, 1'b1, bits);
        wait_pulse(d0, e0, 200);
        checks++;
        if (bits !== exp_frame) begin
            errors++;
            $display("FAIL frame_bits byte %02h got %03h exp %03h", b, bits, exp_frame);
        end
        checks++;
        if (done_cnt != d0 + 1 || err_cnt != e0) begin
            errors++;
            $display("FAIL done_once done %0d err %0d exp %0d %0d", done_cnt - d0, err_cnt - e0, 1, 0);
        end
        checks++;
        if (ready_at_pulse !== 1'b0 || ready_after_pulse !== 1'b1) begin
            errors++;
            $display("FAIL ready_around_done got %0b%0b exp 01", ready_at_pulse, ready_after_pulse);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_ready, tx_done, tx_error, busy, clk_drv, data_drv} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs got %06b exp 100000", {tx_ready, tx_done, tx_error, busy, clk_drv, data_drv});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset ready/busy got %0b%0b exp 10", tx_ready, busy);
        end
    endtask

    task automatic test_send_f4();
        run_xfer(8'hF4, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int bad;
        fork
            run_xfer(8'hED, 1'b1, 0);
            begin
                repeat (250) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (clk_drv !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL dropped_valid bad_cycles got %0d exp 0", bad);
        end
        run_xfer(8'h00, 1'b1, 0);
        checks++;
        if (ready_viol != 0) begin
            errors++;
            $display("FAIL ready_low_while_busy violations got %0d exp 0", ready_viol);
        end
    endtask

    task automatic test_nack();
        int         d0, e0;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hFF, 0);
        dev_frame(11, 1'b0, bits);
        wait_pulse(d0, e0, 200);
        checks++;
        if (bits !== 10'h3FF) begin
            errors++;
            $display("FAIL nack_frame_bits got %03h exp 3ff", bits);
        end
        checks++;
        if (err_cnt != e0 + 1 || done_cnt != d0) begin
            errors++;
            $display("FAIL nack_pulses err %0d done %0d exp 1 0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (err_cyc - last_fall_cyc != SYNC + 1) begin
            errors++;
            $display("FAIL nack_latency got %0d exp %0d", err_cyc - last_fall_cyc, SYNC + 1);
        end
        checks++;
        if (drv_at_pulse !== 2'b00 || clk_drv !== 1'b0 || data_drv !== 1'b0) begin
            errors++;
            $display("FAIL nack_release got %02b exp 00", drv_at_pulse);
        end
        checks++;
        if (ready_after_pulse !== 1'b1) begin
            errors++;
            $display("FAIL nack_ready_after got %0b exp 1", ready_after_pulse);
        end
    endtask

    task automatic test_timeout();
        int         d0, e0;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hF4, 0);
        dev_frame(4, 1'b1, bits);
        wait_pulse(d0, e0, 3 * TO);
        checks++;
        if (err_cnt != e0 + 1 || done_cnt != d0) begin
            errors++;
            $display("FAIL timeout_pulses err %0d done %0d exp 1 0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (err_cyc - release_cyc != TO) begin
            errors++;
            $display("FAIL timeout_latency got %0d exp %0d", err_cyc - release_cyc, TO);
        end
        checks++;
        if (drv_at_pulse !== 2'b00) begin
            errors++;
            $display("FAIL timeout_release got %02b exp 00", drv_at_pulse);
        end
        checks++;
        if (ready_after_pulse !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready_after got %0b exp 1", ready_after_pulse);
        end
    endtask

    task automatic test_reset_mid();
        int         d0, e0, f0, g;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        f0 = fall_cnt;
        start_tx(8'hF4, 0);
        fork
            dev_frame(11, 1'b1, bits);
            begin
                g = 0;
                while (fall_cnt < f0 + 6 && g < 4000) begin
                    @(negedge clk);
                    g++;
                end
                rst_n   = 1'b0;
                in_xfer = 1'b0;
                @(negedge clk);
                checks++;
                if ({tx_ready, tx_done, tx_error, busy, clk_drv, data_drv} !== 6'b100000) begin
                    errors++;
                    $display("FAIL reset_mid_outputs got %06b exp 100000", {tx_ready, tx_done, tx_error, busy, clk_drv, data_drv});
                end
                rst_n = 1'b1;
            end
        join
        repeat (50) @(negedge clk);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            errors++;
            $display("FAIL reset_mid_no_pulse done %0d err %0d exp 0 0", done_cnt - d0, err_cnt - e0);
        end
        run_xfer(8'hF4, 1'b0, 0);
    endtask

    task automatic test_glitch();
        run_xfer(8'hF4, 1'b0, 20);
    endtask

    task automatic test_pulse_integrity();
        checks++;
        if (both_cnt != 0 || long_cnt != 0) begin
            errors++;
            $display("FAIL pulse_integrity overlap %0d long %0d exp 0 0", both_cnt, long_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_send_f4();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_glitch();
        test_pulse_integrity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(60000 * 20);
        errors++;
        $display("FAIL watchdog simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end
endmodule
